dram_ctrl_4164: RTL
===================

Name: dram_ctrl_4164

Overview:
- Synchronous controller that turns single-byte CPU memory requests into 4164 DRAM strobe sequences.
- Drives a bank of eight 4164 devices (64K x 8) through the multiplexed 8-bit address bus: nRAS, nCAS and nWE.
- Generates periodic RAS-only refresh.
- Sits directly upstream of the 4164 RAM models, between the CPU bus interface and the DRAM bank.

Parameters:
- RCD_CYCLES, 2: clocks nRAS is low with the row address before the column address is muxed.
- CAS_CYCLES, 3: clocks nCAS is held low.
- RP_CYCLES, 2: precharge clocks with all strobes high after any cycle.
- REF_RAS_CYCLES, 3: clocks nRAS is low during a refresh.
- REFRESH_INTERVAL, 234: clocks between refresh requests. Legal range 16..65535.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  access request, level; sampled only in IDLE
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  16  byte address; row = addr[7:0], column = addr[15:8]
- wdata  in  8  write data; sampled with req
- rdata  out  8  read data, valid while ack = 1 and held until next read ack
- ack  out  1  one-clock pulse marking access completion
- busy  out  1  high whenever state != IDLE
- ram_a  out  8  multiplexed DRAM address
- ram_nras  out  1  row strobe, active low
- ram_ncas  out  1  column strobe, active low
- ram_nwe  out  1  write enable, active low
- ram_d  out  8  write data to the DRAM di pins
- ram_q  in  8  DRAM do pins; may be z/x when nCAS is high

Behaviour:
- Clock and reset:
  - One clock domain. Reset is synchronous and active-high, one clock.
  - On reset: state = IDLE; ram_nras = ram_ncas = ram_nwe = 1; ram_a = 0; ram_d = 0; rdata = 0; ack = 0; refresh timer = 0; refresh row counter = 0; refresh pending = 0.
  - Reset asserted mid-cycle returns all strobes high on the next clock. No partial completion and no ack.
- States: IDLE, ROW, RAS, COL, CAS, PRE, REF_ROW, REF_RAS. All outputs are registered.
- IDLE:
  - Strobes high.
  - If refresh pending → REF_ROW. Refresh has priority over a simultaneous req.
  - Else if req → latch addr, we and wdata, then → ROW.
- ROW (1 clk): ram_a = addr[7:0], nRAS high (address setup).
- RAS (RCD_CYCLES): nRAS low, ram_a = row.
- COL (1 clk):
  - ram_a = addr[15:8], nRAS low.
  - On write: nWE low and ram_d = wdata (early write; nWE falls before nCAS).
- CAS (CAS_CYCLES):
  - nCAS low. nWE stays low on write.
  - On the last CAS clock, a read samples ram_q into rdata.
- PRE (RP_CYCLES):
  - nRAS, nCAS and nWE high.
  - ack = 1 on the first PRE clock only, for reads and writes.
  - After precharge → IDLE.
- Access latency:
  - ack rises 1 + RCD_CYCLES + 1 + CAS_CYCLES clocks after the accepting edge (7 with defaults).
  - Next req can be accepted RP_CYCLES clocks after ack rises.
  - A requester still holding req in IDLE starts a new access. Requesters drop req on ack.
- Refresh:
  - Free-running timer. On reaching REFRESH_INTERVAL-1 it sets pending and restarts from 0.
  - A second expiry while pending is already set is absorbed: one pending flag, no queue.
  - REF_ROW (1 clk): ram_a = refresh row counter, strobes high.
  - REF_RAS (REF_RAS_CYCLES): nRAS low, nCAS high, nWE high.
  - Then PRE: no ack; clear pending; row counter += 1, wrapping 255 → 0.
  - A req arriving during refresh waits, held, until IDLE.
- Strobe invariants:
  - nCAS never low while nRAS is high.
  - nWE only low while nRAS is low.
  - ram_a is stable on every clock in which nRAS or nCAS falls.

Test Plan:
- Write: after reset, req = 1, we = 1, addr = 0xA4A2, wdata = 0x5A.
  - Required sequence: ram_a = 0xA2 with nRAS falling; nWE low; ram_a = 0xA4 with nCAS falling; ram_d = 0x5A.
  - ack pulses exactly 7 clocks after acceptance. All strobes high during PRE.
- Read-back: req = 1, we = 0, addr = 0xA4A2 on the 4164 bank.
  - rdata = 0x5A with ack; nWE stays high throughout.
  - Read of 0x0001 after writing 0x11 there returns 0x11.
- Refresh: REFRESH_INTERVAL = 16, no requests.
  - RAS-only cycle every 16 clocks; ram_a = 0x00, then 0x01, then 0x02.
  - nCAS stays high; no ack.
- Collision: req asserted on the same clock the refresh becomes pending.
  - Refresh runs first, then the access.
  - ack arrives 1 + REF_RAS_CYCLES + RP_CYCLES clocks later than the uncontended case; data is correct.
- Wrap: after 256 refreshes the refresh row returns to 0x00 (0xFF → 0x00).
- Reset mid-access: assert rst during CAS of a write.
  - Next clock: nRAS = nCAS = nWE = 1, ack = 0, busy = 0.
  - Refresh row counter = 0.

Source files
------------

// File: rtl/dram_ctrl_4164_if.sv
// dram_ctrl_4164_if: CPU-side byte access bus of the 4164 DRAM controller
// Signals: req/we/addr/wdata (requester -> controller), rdata/ack/busy (controller -> requester).
// Modports: master = CPU side, slave = controller side.
interface dram_ctrl_4164_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ack;
    logic        busy;
    modport master (output req, we, addr, wdata, input rdata, ack, busy);
    modport slave (input req, we, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/dram_ctrl_4164.sv
// dram_ctrl_4164: turns single-byte CPU requests into 4164 RAS/CAS/WE sequences with RAS-only refresh
// Ports: clk, rst (synchronous, active high); bus (slave modport): req/we/addr/wdata in, rdata/ack/busy out;
//        ram_a/ram_nras/ram_ncas/ram_nwe/ram_d drive the eight-device bank, ram_q returns its read data.
module dram_ctrl_4164 #(
    parameter int RCD_CYCLES       = 2,
    parameter int CAS_CYCLES       = 3,
    parameter int RP_CYCLES        = 2,
    parameter int REF_RAS_CYCLES   = 3,
    parameter int REFRESH_INTERVAL = 234
) (
    input  logic             clk,
    input  logic             rst,
    dram_ctrl_4164_if.slave  bus,
    output logic [7:0]       ram_a,
    output logic             ram_nras,
    output logic             ram_ncas,
    output logic             ram_nwe,
    output logic [7:0]       ram_d,
    input  logic [7:0]       ram_q
);
    typedef enum logic [2:0] {IDLE, ROW, RAS, COL, CAS, PRE, REF_ROW, REF_RAS} state_t;
    // Timed states load cnt with their length minus one and leave when it reaches zero.
    localparam logic [7:0]  RCD_L  = 8'(RCD_CYCLES - 1);
    localparam logic [7:0]  CAS_L  = 8'(CAS_CYCLES - 1);
    localparam logic [7:0]  RP_L   = 8'(RP_CYCLES - 1);
    localparam logic [7:0]  RRAS_L = 8'(REF_RAS_CYCLES - 1);
    localparam logic [15:0] REF_L  = 16'(REFRESH_INTERVAL - 1);
    state_t      state, nxt, dispatch;
    logic [7:0]  cnt, cnt_nxt, ref_row, wd_q;
    logic [15:0] a_q, a_n, timer;
    logic        we_q, pending, last, accept, expire, ref_done;
    always_comb begin
        last     = cnt == 8'd0;
        // The end of precharge makes the same decision as IDLE, so a held request
        // is taken without an extra idle clock.
        dispatch = pending ? REF_ROW : (bus.req ? ROW : IDLE);
        accept   = (state == IDLE || (state == PRE && last)) && !pending && bus.req;
        expire   = timer == REF_L;
        ref_done = state == REF_RAS && last;
        a_n      = accept ? bus.addr : a_q;
        nxt      = state;
        cnt_nxt  = cnt - 8'd1;
        case (state)
            IDLE:    nxt = dispatch;
            ROW:     begin nxt = RAS; cnt_nxt = RCD_L; end
            RAS:     nxt = last ? COL : RAS;
            COL:     begin nxt = CAS; cnt_nxt = CAS_L; end
            CAS:     begin nxt = last ? PRE : CAS; cnt_nxt = last ? RP_L : cnt - 8'd1; end
            PRE:     nxt = last ? dispatch : PRE;
            REF_ROW: begin nxt = REF_RAS; cnt_nxt = RRAS_L; end
            REF_RAS: begin nxt = last ? PRE : REF_RAS; cnt_nxt = last ? RP_L : cnt - 8'd1; end
            default: nxt = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_q       <= '0;
            we_q      <= 1'b0;
            wd_q      <= '0;
            timer     <= '0;
            pending   <= 1'b0;
            ref_row   <= '0;
            ram_a     <= '0;
            ram_nras  <= 1'b1;
            ram_ncas  <= 1'b1;
            ram_nwe   <= 1'b1;
            ram_d     <= '0;
            bus.rdata <= '0;
            bus.ack   <= 1'b0;
            bus.busy  <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                a_q  <= bus.addr;
                we_q <= bus.we;
                wd_q <= bus.wdata;
            end
            timer     <= expire ? '0 : timer + 16'd1;
            // An expiry while already pending merges into the single flag.
            pending   <= expire || (pending && !ref_done);
            ref_row   <= ref_row + 8'(ref_done);
            ram_nras  <= !(nxt inside {RAS, COL, CAS, REF_RAS});
            ram_ncas  <= nxt != CAS;
            ram_nwe   <= !(we_q && (nxt == COL || nxt == CAS));
            ram_a     <= (nxt == ROW || nxt == RAS) ? a_n[7:0] :
                         (nxt == COL || nxt == CAS) ? a_n[15:8] :
                         (nxt == REF_ROW || nxt == REF_RAS) ? ref_row : ram_a;
            ram_d     <= (nxt == COL && we_q) ? wd_q : ram_d;
            bus.rdata <= (state == CAS && last && !we_q) ? ram_q : bus.rdata;
            bus.ack   <= state == CAS && last;
            bus.busy  <= nxt != IDLE;
        end
    end
endmodule
